// File: rtl/fwd_ctrl.sv
// fwd_ctrl: registered EX operand forwarding selects and combinational load-use stall.
// Define STALL_COUNT_EN to add a saturating stall-cycle counter on stall_count.
module fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_meta_t;

    // WB-distance hits go through the register file, so the WB entry
    // never influences an output; MEM only needs "writing" and rd.
    ex_meta_t              ex_q, ex_d;
    logic                  mem_wr_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [1:0]            fwd_a_q, fwd_a_d;
    logic [1:0]            fwd_b_q, fwd_b_d;

    logic ex_wr;
    logic a_ex, a_mem, b_ex, b_mem;
    logic load_hit;
    logic bubble;

    assign ex_wr = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0);

    assign a_ex  = id_uses_rs1 & ex_wr & (id_rs1 == ex_q.rd);
    assign b_ex  = id_uses_rs2 & ex_wr & (id_rs2 == ex_q.rd);
    assign a_mem = id_uses_rs1 & mem_wr_q & (id_rs1 == mem_rd_q);
    assign b_mem = id_uses_rs2 & mem_wr_q & (id_rs2 == mem_rd_q);

    assign load_hit = ex_q.mem_read & (a_ex | b_ex);
    assign stall    = id_valid & ~flush & load_hit;
    assign bubble   = ~id_valid | stall | flush;

    // Youngest producer (EX) wins over MEM.
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (a_ex) begin
            fwd_a_d = 2'b01;
        end else if (a_mem) begin
            fwd_a_d = 2'b10;
        end
        if (b_ex) begin
            fwd_b_d = 2'b01;
        end else if (b_mem) begin
            fwd_b_d = 2'b10;
        end
        if (bubble) begin
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q     <= '0;
            mem_wr_q <= 1'b0;
            mem_rd_q <= '0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            ex_q     <= ex_d;
            mem_wr_q <= ex_wr;
            mem_rd_q <= ex_q.rd;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and hazard controller that drives the 2-bit select inputs of the EX-stage three-input operand multiplexers. It keeps a shadow pipeline of destination-register metadata for EX, MEM and WB. From that metadata it produces registered per-operand forwarding selects and a combinational load-use stall. It sits beside the ID/EX pipeline register. It produces the select codes the operand muxes consume.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, stall-counter width (used only with STALL_COUNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source register addresses of the ID instruction.
- id_uses_rs1, id_uses_rs2  in  1  the instruction actually reads rs1/rs2.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes rd.
- id_mem_read  in  1  the ID instruction is a load.
- flush  in  1  taken branch or jump; kills the ID instruction.
- fwd_a, fwd_b  out  2  EX operand selects: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data. 11 is never driven.
- stall  out  1  combinational load-use stall; holds PC and IF/ID, and inserts a bubble.
- stall_count  out  CNT_W  count of stall cycles (see Configuration).

## Operation
- Shadow stages EX, MEM and WB each hold {valid, rd, reg_write, mem_read}. Reset clears every valid bit.
- On each edge: MEM→WB, EX→MEM, and the ID instruction →EX.
  - A bubble (valid=0) enters EX when any of !id_valid, stall or flush is true.
- An entry is "writing" when valid & reg_write & rd≠0. Register x0 is never forwarded.
- Select computation for operand A happens in ID and is registered into fwd_a. Operand B is identical, using rs2 and fwd_b.
  - If id_uses_rs1 and the EX entry is writing with rd==id_rs1: next fwd_a=01. That instruction will be in MEM when the ID instruction reaches EX.
  - Otherwise, if the MEM entry is writing with rd==id_rs1: next fwd_a=10.
  - Otherwise: next fwd_a=00.
  - EX matches take priority over MEM matches, so the youngest producer wins.
- Matches against the WB entry are not forwarded. The register file handles write-before-read at that distance.
- stall = id_valid & !flush & EX.valid & EX.mem_read & EX.reg_write & EX.rd≠0 & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
- During a stall, the ID instruction is re-presented next cycle unchanged. The load has then moved to MEM, so the re-evaluation yields select 10 and stall=0.
- When a stall or flush inserts a bubble, the registered fwd_a and fwd_b load 00.
- flush and stall asserted in the same cycle: flush wins; stall reads 0 and a bubble enters EX.

## Timing
- Reset values: fwd_a=00, fwd_b=00, stall=0, stall_count=0, all shadow valid=0. Reset applies asynchronously on arst_n falling and releases synchronously to the next edge.
- fwd_a and fwd_b have one-cycle latency. They are valid during the cycle the corresponding instruction occupies EX.
- stall has zero latency: it is combinational in the same cycle the dependent instruction is in ID.
- Each load-use dependency costs exactly one stall cycle; no stall exceeds one consecutive cycle for a single dependency.
- Reset asserted mid-stall: stall drops to 0 immediately, because EX.valid clears asynchronously.

## Configuration
- STALL_COUNT_EN defined: stall_count increments by 1 on every edge where stall=1. It saturates at all-ones and does not wrap. Reset clears it.
- STALL_COUNT_EN undefined: no counter is implemented and stall_count is tied to 0.

## Test plan
- Back-to-back dependency:
  - Stimulus: ADD x5←… then SUB reading rs1=x5 on the next cycle.
  - Required: fwd_a=01 while SUB is in EX; stall never asserts.
- Distance-two dependency:
  - Stimulus: producer writes x7, one independent instruction follows, then a consumer uses rs2=x7.
  - Required: fwd_b=10 and fwd_a=00.
- Load-use:
  - Stimulus: LW x3 then ADD reading rs1=x3.
  - Required: stall=1 for exactly one cycle. The bubble yields fwd=00 in EX for that cycle. Next cycle stall=0, and fwd_a=10 when ADD is in EX. With STALL_COUNT_EN, stall_count goes 0→1.
- x0 and priority:
  - Stimulus: producers write x0 in both EX and MEM and the consumer reads x0 → required fwd=00.
  - Stimulus: EX and MEM both write x9 and the consumer reads x9 → required fwd=01.
- Flush:
  - Stimulus: flush asserted while a load-use condition is present in ID.
  - Required: stall=0, a bubble enters EX, and next fwd_a=fwd_b=00.
- Reset:
  - Stimulus: drop arst_n during a stall cycle.
  - Required: stall, fwd_a, fwd_b and stall_count are 0 immediately. The first post-reset instruction sees fwd=00.
